divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have a parameter WS, default 16, giving the dividend, divisor, quotient and remainder width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the dividend/divisor pair is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 The block SHALL have port dividend, input, WS bits: unsigned numerator.
REQ-007 The block SHALL have port divisor, input, WS bits: unsigned denominator.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port quotient, output, WS bits: unsigned quotient.
REQ-011 The block SHALL have port remainder, output, WS bits: unsigned remainder.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: the captured divisor was 0.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 An accept SHALL occur on an edge where in_valid && in_ready; on that edge the block SHALL capture dividend and divisor, clear the quotient, clear the partial remainder (WS+1 bits), clear the iteration counter and enter BUSY.
REQ-016 In BUSY, each edge SHALL perform one restoring step: shift the partial remainder left, inserting the next dividend bit (MSB first).
REQ-017 In the same step, if the shifted value is >= divisor (zero-extended), the block SHALL subtract the divisor and shift 1 into the quotient; otherwise it SHALL shift 0 into the quotient.
REQ-018 After exactly WS BUSY steps the block SHALL enter DONE, so out_valid rises WS edges after the accepting edge; latency SHALL be fixed and independent of operand values.
REQ-019 For divisor 0 the block SHALL run the same algorithm unchanged, producing quotient all-ones, remainder = dividend and div_by_zero = 1, with the same latency.
REQ-020 quotient, remainder and div_by_zero SHALL remain stable while out_valid = 1 && out_ready = 0.
REQ-021 An edge with out_valid && out_ready SHALL return the FSM to IDLE.
REQ-022 Because in_ready = 0 in DONE, the block SHALL NOT accept a new pair on the same edge that a result is consumed.
REQ-023 in_valid and the input data SHALL be ignored in BUSY and DONE; input changes after the accept SHALL NOT affect the result.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 The block SHALL contain a clocked self-check, disabled while rst_n = 0. Whenever out_valid = 1 and div_by_zero = 0, it SHALL require quotient*divisor + remainder == dividend, evaluated at 2*WS bits, and remainder < divisor.
REQ-026 The block SHALL contain a second clocked self-check requiring that out_valid and in_ready are never 1 together.
REQ-027 The formal environment SHALL constrain rst_n to be 0 exactly in the initial state.

Reset
REQ-028 While rst_n = 0 at an edge, the block SHALL enter IDLE and clear the quotient, partial remainder, captured operands, counter and div_by_zero to 0.
REQ-029 The cycle after a reset edge SHALL show in_ready = 1, out_valid = 0, quotient = 0, remainder = 0 and div_by_zero = 0.
REQ-030 Reset asserted in BUSY or DONE SHALL abort the operation and discard its result; no out_valid SHALL follow from the aborted operation.

Verification
REQ-031 Basic: WS=16, accept 100/7 -> out_valid 16 edges later with quotient 14, remainder 2, div_by_zero 0.
REQ-032 Extremes: 0xFFFF/1 -> quotient 0xFFFF, remainder 0; then 3/10 -> quotient 0, remainder 3.
REQ-033 Divide by zero: 5/0 -> quotient 0xFFFF, remainder 5, div_by_zero 1, same 16-edge latency.
REQ-034 Backpressure: hold out_ready = 0 for 3 cycles in DONE -> outputs unchanged and in_ready = 0; raise out_ready -> IDLE next cycle; a new pair is accepted only after that.
REQ-035 Input churn: change dividend/divisor every cycle during BUSY -> result matches the captured pair.
REQ-036 Reset mid-BUSY: assert rst_n = 0 at step 8 of 200/3 -> next cycle in_ready = 1, out_valid = 0, quotient = 0; no stale result appears.

Source files
------------

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, fixed WS-cycle
// latency, valid/ready handshake on both sides.
module divider #(
    parameter int WS = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WS-1:0] dividend,
    input  logic [WS-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WS-1:0] quotient,
    output logic [WS-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(WS + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [WS-1:0] dvd_q, dvs_q, dvd_sh, quot;
    logic [WS:0]   prem, shifted;
    logic [CW-1:0] cnt;
    logic          dbz, fits, last_step;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = quot;
    assign remainder   = prem[WS-1:0];
    assign div_by_zero = dbz;

    // dvd_sh feeds dividend bits MSB first; dvd_q keeps the original for the self-check.
    assign shifted   = {prem[WS-1:0], dvd_sh[WS-1]};
    assign fits      = (shifted >= {1'b0, dvs_q});
    assign last_step = (cnt == CW'(WS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A zero divisor needs no special path: every step "fits", giving all-ones / dividend.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            dvd_sh <= '0;
            quot   <= '0;
            prem   <= '0;
            cnt    <= '0;
            dbz    <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            dvd_sh <= dividend;
            quot   <= '0;
            prem   <= '0;
            cnt    <= '0;
            dbz    <= (divisor == '0);
        end else if (state == BUSY) begin
            prem   <= fits ? (shifted - {1'b0, dvs_q}) : shifted;
            quot   <= {quot[WS-2:0], fits};
            dvd_sh <= {dvd_sh[WS-2:0], 1'b0};
            cnt    <= cnt + CW'(1);
        end
    end

    logic [2*WS-1:0] chk_lhs, chk_rhs;
    assign chk_lhs = {{WS{1'b0}}, quot} * {{WS{1'b0}}, dvs_q} + {{WS{1'b0}}, prem[WS-1:0]};
    assign chk_rhs = {{WS{1'b0}}, dvd_q};

    a_result_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !dbz) |-> (chk_lhs == chk_rhs && prem[WS-1:0] < dvs_q));

    a_handshake_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(out_valid && in_ready));

`ifdef FORMAL
    // Reset is held low in the initial state only.
    logic f_init = 1'b1;
    always_ff @(posedge clk) f_init <= 1'b0;
    always_comb assume (f_init == !rst_n);
`endif

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: scoreboard of expected results checked with
// immediate assertions as each result is presented.
module tb_divider;

    localparam int WS = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [WS-1:0] dividend;
    logic [WS-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [WS-1:0] quotient;
    logic [WS-1:0] remainder;
    logic          div_by_zero;

    typedef struct {
        logic [WS-1:0] q;
        logic [WS-1:0] r;
        logic          z;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    divider #(.WS(WS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a pair and hold it until the accepting edge; optionally record the expected result.
    task automatic accept(input logic [WS-1:0] a, input logic [WS-1:0] b, input bit push);
        exp_t e;
        int   w;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk("accept_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) begin
            if (b == '0) begin
                e.q = '1;
                e.r = a;
                e.z = 1'b1;
            end else begin
                e.q = a / b;
                e.r = a % b;
                e.z = 1'b0;
            end
            sb.push_back(e);
        end
    endtask

    task automatic wait_result(input bit churn, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (churn) begin
                dividend = 16'($urandom);
                divisor  = 16'($urandom);
                in_valid = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        chk("out_valid_seen", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_quotient"},  {16'b0, quotient},    {16'b0, e.q});
        chk({tag, "_remainder"}, {16'b0, remainder},   {16'b0, e.r});
        chk({tag, "_dbz"},       {31'b0, div_by_zero}, {31'b0, e.z});
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle_in_ready"},  {31'b0, in_ready},  32'd1);
        chk({tag, "_idle_out_valid"}, {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run_op(input logic [WS-1:0] a, input logic [WS-1:0] b, input string tag);
        int lat;
        accept(a, b, 1'b1);
        wait_result(1'b0, lat);
        chk({tag, "_latency"}, 32'(lat), 32'd16);
        check_result(tag);
        consume(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'b0, in_ready},    32'd1);
        chk("rst_out_valid", {31'b0, out_valid},   32'd0);
        chk("rst_quotient",  {16'b0, quotient},    32'd0);
        chk("rst_remainder", {16'b0, remainder},   32'd0);
        chk("rst_dbz",       {31'b0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'd100,   16'd7,  "basic");
        run_op(16'hFFFF,  16'd1,  "max_by_one");
        run_op(16'd3,     16'd10, "small_by_big");
        run_op(16'd5,     16'd0,  "div_zero");

        // Backpressure: result must hold, and a pending offer must not be taken in DONE.
        accept(16'd1234, 16'd56, 1'b1);
        wait_result(1'b0, lat);
        chk("bp_latency", 32'(lat), 32'd16);
        check_result("bp");
        dividend = 16'd77;
        divisor  = 16'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_quotient",  {16'b0, quotient},    32'd22);
            chk("bp_hold_remainder", {16'b0, remainder},   32'd2);
            chk("bp_hold_dbz",       {31'b0, div_by_zero}, 32'd0);
            chk("bp_hold_out_valid", {31'b0, out_valid},   32'd1);
            chk("bp_hold_in_ready",  {31'b0, in_ready},    32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready",  {31'b0, in_ready},  32'd1);
        chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
        accept(16'd77, 16'd5, 1'b1);
        wait_result(1'b0, lat);
        chk("bp_next_latency", 32'(lat), 32'd16);
        check_result("bp_next");
        consume("bp_next");

        // Inputs churn every cycle while busy.
        accept(16'd50000, 16'd123, 1'b1);
        wait_result(1'b1, lat);
        chk("churn_latency", 32'(lat), 32'd16);
        check_result("churn");
        consume("churn");

        // Reset partway through an operation.
        accept(16'd200, 16'd3, 1'b0);
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready",  {31'b0, in_ready},    32'd1);
        chk("midrst_out_valid", {31'b0, out_valid},   32'd0);
        chk("midrst_quotient",  {16'b0, quotient},    32'd0);
        chk("midrst_remainder", {16'b0, remainder},   32'd0);
        chk("midrst_dbz",       {31'b0, div_by_zero}, 32'd0);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            seen += int'(out_valid);
        end
        chk("midrst_no_stale", 32'(seen), 32'd0);
        run_op(16'd200, 16'd3, "after_rst");

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
